// File: rtl/serial_adder16_if.sv
// Operand/result handshake bundle for serial_adder16.
//   in_valid/in_ready   : operand channel (a, b, cin)
//   out_valid/out_ready : result channel (sum, cout, overflow)
// master = producer of operands / consumer of results, slave = the adder.
interface serial_adder16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder16.sv
// Bit-serial two's-complement adder, one bit per clock, LSB first.
// Each bit slice is a full adder made of two half-adder stages plus an OR
// of their carries; a carry flop links successive slices.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_adder16_if.slave (operand and result valid/ready channels)
// Result latency is WIDTH cycles from the operand handshake; one result per
// WIDTH+2 cycles at best.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding one bit per cycle, cnt = bit index in progress
// DONE  | result presented, out_valid high until out_ready
module serial_adder16 #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  serial_adder16_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only the upper WIDTH-1 result bits need storing; the final bit goes
  // straight from the full adder into the output register.
  logic [WIDTH-2:0] sum_sr;
  logic             carry;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             overflow_r;
  logic             out_valid_r;

  logic ha1_s, ha1_c, ha2_s, ha2_c, carry_nxt;
  logic [WIDTH-1:0] sum_nxt;

  // full adder = half adder (a, b) followed by half adder (partial, carry)
  assign ha1_s     = a_sr[0] ^ b_sr[0];
  assign ha1_c     = a_sr[0] & b_sr[0];
  assign ha2_s     = ha1_s ^ carry;
  assign ha2_c     = ha1_s & carry;
  assign carry_nxt = ha1_c | ha2_c;
  assign sum_nxt   = {ha2_s, sum_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      carry       <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry  <= carry_nxt;
          sum_sr <= sum_nxt[WIDTH-1:1];
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          if (cnt == CNT_LAST) begin
            // carry still holds the carry into the MSB on this cycle
            sum_r       <= sum_nxt;
            cout_r      <= carry_nxt;
            overflow_r  <= carry ^ carry_nxt;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) & rst_n;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_serial_adder16.sv
// Directed and randomised bench for serial_adder16.
module tb_serial_adder16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder16_if #(.WIDTH(16)) bus ();

  serial_adder16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // waits for out_valid, bounded; expects it exactly 16 edges after accept
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (bus.out_valid) break;
    end
    chk({tag, ".latency"}, 32'(n), 32'd16);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.b = b; bus.cin = ci; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.a = 16'h0; bus.b = 16'h0; bus.cin = 1'b0;
    wait_done(tag);
    chk({tag, ".sum"}, 32'(bus.sum), 32'(es));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(eo));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, ".taken"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin : main
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] ev;
    logic        eo;
    int          prev_acc;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = 16'h0; bus.b = 16'h0; bus.cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.sum", 32'(bus.sum), 32'd0);
    chk("rst.cout", 32'(bus.cout), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", 32'(bus.in_ready), 32'd1);

    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "one_plus_one");
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ffff_plus_1");
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
    do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "cin_wrap");
    do_op(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, "min_minus1");
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "mixed");

    // backpressure: 3+4+1 held in DONE for 5 cycles, stray in_valid pulse
    bus.a = 16'h0003; bus.b = 16'h0004; bus.cin = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_done("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.sum", 32'(bus.sum), 32'h0008);
      chk("bp.cout", 32'(bus.cout), 32'd0);
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      if (i == 2) begin
        bus.in_valid = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1;
      end
      step();
      bus.in_valid = 1'b0; bus.a = 16'h0; bus.b = 16'h0; bus.cin = 1'b0;
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp.taken", 32'(bus.out_valid), 32'd0);
    chk("bp.idle", 32'(bus.in_ready), 32'd1);
    do_op(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, "after_bp");

    // reset while bit 7 of 0x1234+0x4321 is in progress
    bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst.sum", 32'(bus.sum), 32'd0);
    chk("mid_rst.in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("mid_rst.rel_ready", 32'(bus.in_ready), 32'd1);
    repeat (20) step();
    chk("mid_rst.no_result", 32'(bus.out_valid), 32'd0);
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "post_rst");

    // streaming with in_valid and out_ready held high
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    prev_acc = 0;
    for (int k = 0; k < 1000; k++) begin
      chk("rnd.in_ready", 32'(bus.in_ready), 32'd1);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ev = 17'(ra) + 17'(rb) + 17'(rc);
      eo = (ra[15] == rb[15]) && (ev[15] != ra[15]);
      bus.a = ra; bus.b = rb; bus.cin = rc;
      step();
      if (k > 0) chk("rnd.period", 32'(cyc - prev_acc), 32'd18);
      prev_acc = cyc;
      wait_done("rnd");
      chk("rnd.sum", 32'(bus.sum), 32'(ev[15:0]));
      chk("rnd.cout", 32'(bus.cout), 32'(ev[16]));
      chk("rnd.ovf", 32'(bus.overflow), 32'(eo));
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
